// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// reset/NOP constants and word-alignment helper.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] PC_STEP          = 32'h0000_0004;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: reset to RESET_PC, load a redirect target,
// or advance by one word (modulo 2^32).
module fetch_stage_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        inc,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    assign pc_plus4 = pc_q + PC_STEP;
    assign pc       = pc_q;

    // Next-PC select: a redirect load always wins over sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = align_word(target);
        end else if (inc) begin
            pc_d = pc_plus4;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= align_word(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: request/grant/response fetch FSM with a kill flag
// for squashing an in-flight fetch on redirect, and a registered IF/ID output.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    input  logic        id_ready
);

    fetch_state_e state_q, state_d;
    logic         kill_q, kill_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_pc4_q, if_pc4_d;

    logic         pc_load;
    logic         pc_inc;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_target;

    assign redirect_target = align_word(redirect_pc);

    fetch_stage_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .inc      (pc_inc),
        .target   (redirect_target),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    // Fetch FSM next-state; redirect outranks grant, response and id_ready.
    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        case (state_q)
            FS_REQ: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    if (imem_gnt) begin
                        // Old address was already accepted: its response must be dropped.
                        kill_d  = 1'b1;
                        state_d = FS_WAIT;
                    end else begin
                        state_d = FS_REQ;
                    end
                end else if (imem_gnt) begin
                    state_d = FS_WAIT;
                end else begin
                    state_d = FS_REQ;
                end
            end
            FS_WAIT: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = FS_REQ;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = FS_WAIT;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = FS_REQ;
                    end else begin
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc;
                        if_pc4_d   = pc_plus4;
                        pc_inc     = 1'b1;
                        state_d    = FS_HOLD;
                    end
                end else begin
                    state_d = FS_WAIT;
                end
            end
            FS_HOLD: begin
                if (redirect_valid) begin
                    // Held instruction is squashed even if id_ready is high now.
                    if_valid_d = 1'b0;
                    pc_load    = 1'b1;
                    state_d    = FS_REQ;
                end else if (id_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = FS_REQ;
                end else begin
                    state_d = FS_HOLD;
                end
            end
            default: begin
                state_d    = FS_REQ;
                kill_d     = 1'b0;
                if_valid_d = 1'b0;
            end
        endcase
    end

    // FSM, kill flag and IF/ID output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FS_REQ;
            kill_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= NOP_WORD;
            if_pc_q    <= 32'h0000_0000;
            if_pc4_q   <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
        end
    end

    assign imem_req  = (state_q == FS_REQ);
    assign imem_addr = pc;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_pc4    = if_pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a transaction-level memory model plus
// a reference model of "next PC to be delivered", with directed and random scenarios.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        id_ready;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // memory model state
    bit          pending = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int unsigned pend_delay = 0;
    int unsigned gnt_pct = 100;
    int unsigned lat_min = 0;
    int unsigned lat_max = 0;
    int unsigned spur_pct = 0;

    // reference model: PC of the next instruction the stage must present
    logic [31:0] exp_pc = RST_PC;
    int          delivered = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .id_ready       (id_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    // One clock: advance memory + reference model, scoreboard outputs, drive memory.
    task automatic step();
        logic        req_b, gnt_b, rv_b, redir_b, rdy_b, val_b, rst_b;
        logic [31:0] addr_b, rpc_b;
        req_b = imem_req; gnt_b = imem_gnt; rv_b = imem_rvalid; addr_b = imem_addr;
        redir_b = redirect_valid; rpc_b = redirect_pc; rdy_b = id_ready;
        val_b = if_valid; rst_b = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_b) begin
            pending = 1'b0;
        end else begin
            if (rv_b && pending) pending = 1'b0;
            if (req_b === 1'b1 && gnt_b) begin
                pending    = 1'b1;
                pend_addr  = addr_b;
                pend_delay = $urandom_range(lat_max, lat_min);
            end
        end
        if (rst_b) begin
            exp_pc = RST_PC;
        end else if (redir_b) begin
            exp_pc = rpc_b & 32'hFFFF_FFFC;
        end else if (val_b && rdy_b) begin
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        checks++;
        if ((imem_req && if_valid) !== 1'b0) begin
            failures++;
            $display("FAIL req_while_valid: imem_req=%b if_valid=%b required not both", imem_req, if_valid);
        end
        if (imem_req === 1'b1) begin
            checks++;
            if (pending) begin
                failures++;
                $display("FAIL second_outstanding: imem_req=1 with a response still pending (addr %h)", pend_addr);
            end
        end
        if (if_valid === 1'b1) begin
            checks++;
            if (if_pc !== exp_pc) begin
                failures++;
                $display("FAIL sb_if_pc: got %h required %h (cycle %0d)", if_pc, exp_pc, cyc);
            end
            checks++;
            if (if_instr !== mem_word(exp_pc)) begin
                failures++;
                $display("FAIL sb_if_instr: got %h required %h (cycle %0d)", if_instr, mem_word(exp_pc), cyc);
            end
            checks++;
            if (if_pc4 !== exp_pc + 32'd4) begin
                failures++;
                $display("FAIL sb_if_pc4: got %h required %h (cycle %0d)", if_pc4, exp_pc + 32'd4, cyc);
            end
        end
        imem_gnt = (imem_req === 1'b1) && ($urandom_range(100, 1) <= gnt_pct);
        if (pending) begin
            if (pend_delay == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
            end else begin
                pend_delay--;
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
        end else begin
            imem_rvalid = (spur_pct != 0) && ($urandom_range(100, 1) <= spur_pct);
            imem_rdata  = $urandom;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_req: got %b required 1", imem_req); end
        checks++; if (imem_addr !== RST_PC) begin failures++; $display("FAIL reset_addr: got %h required %h", imem_addr, RST_PC); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h required 0", if_pc); end
        checks++; if (if_pc4 !== 32'h0) begin failures++; $display("FAIL reset_pc4: got %h required 0", if_pc4); end
        checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h required 0", if_instr); end
    endtask

    task automatic test_straight_line();
        logic [31:0] pcs [3];
        logic [31:0] pc4s [3];
        int          cys [3];
        int          n = 0;
        id_ready = 1'b1;
        for (int i = 0; i < 40 && n < 3; i++) begin
            step();
            if (if_valid === 1'b1) begin
                pcs[n] = if_pc; pc4s[n] = if_pc4; cys[n] = cyc; n++;
            end
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL straight_count: got %0d deliveries required 3 within 40 cycles", n);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (pcs[k] !== RST_PC + 32'(4 * k)) begin
                    failures++; $display("FAIL straight_pc%0d: got %h required %h", k, pcs[k], RST_PC + 32'(4 * k));
                end
                checks++;
                if (pc4s[k] !== RST_PC + 32'(4 * k + 4)) begin
                    failures++; $display("FAIL straight_pc4_%0d: got %h required %h", k, pc4s[k], RST_PC + 32'(4 * k + 4));
                end
            end
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (cys[k] - cys[k-1] != 3) begin
                    failures++; $display("FAIL straight_spacing%0d: got %0d cycles required 3", k, cys[k] - cys[k-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held_pc, held_instr;
        id_ready = 1'b0;
        for (int i = 0; i < 20 && if_valid !== 1'b1; i++) step();
        checks++;
        if (if_valid !== 1'b1) begin
            failures++; $display("FAIL bp_arrive: got if_valid=%b required 1 within 20 cycles", if_valid);
        end else begin
            held_pc = if_pc; held_instr = if_instr;
            for (int k = 0; k < 5; k++) begin
                step();
                checks++;
                if (if_valid !== 1'b1 || if_pc !== held_pc || if_instr !== held_instr) begin
                    failures++; $display("FAIL bp_stable: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                                         if_valid, if_pc, if_instr, held_pc, held_instr);
                end
                checks++;
                if (imem_req !== 1'b0 || imem_addr !== held_pc + 32'd4) begin
                    failures++; $display("FAIL bp_no_fetch: got req=%b addr=%h required req=0 addr=%h",
                                         imem_req, imem_addr, held_pc + 32'd4);
                end
            end
            id_ready = 1'b1;
            step();
            for (int i = 0; i < 20 && if_valid !== 1'b1; i++) step();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== held_pc + 32'd4) begin
                failures++; $display("FAIL bp_next: got v=%b pc=%h required v=1 pc=%h", if_valid, if_pc, held_pc + 32'd4);
            end
        end
    endtask

    task automatic test_redirect_wait();
        logic rv_prev = 1'b0;
        id_ready = 1'b1;
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 20 && !(imem_req === 1'b1 && imem_gnt); i++) step();
        checks++;
        if (!(imem_req === 1'b1 && imem_gnt)) begin
            failures++; $display("FAIL rw_grant: got req=%b gnt=%b required both 1 within 20 cycles", imem_req, imem_gnt);
        end else begin
            step();
            redirect_valid = 1'b1;
            redirect_pc = 32'h0040_0103;
            step();
            redirect_valid = 1'b0;
            for (int i = 0; i < 20 && imem_req !== 1'b1; i++) begin
                rv_prev = imem_rvalid;
                step();
                checks++;
                if (if_valid !== 1'b0) begin
                    failures++; $display("FAIL rw_discard: got if_valid=%b pc=%h required 0", if_valid, if_pc);
                end
            end
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin
                failures++; $display("FAIL rw_addr: got req=%b addr=%h required req=1 addr=00400100", imem_req, imem_addr);
            end
            checks++;
            if (rv_prev !== 1'b1) begin
                failures++; $display("FAIL rw_latency: got rvalid_prev=%b required request right after dropped response", rv_prev);
            end
            lat_min = 0; lat_max = 0;
            for (int i = 0; i < 20 && if_valid !== 1'b1; i++) step();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h0040_0100) begin
                failures++; $display("FAIL rw_deliver: got v=%b pc=%h required v=1 pc=00400100", if_valid, if_pc);
            end
        end
        lat_min = 0; lat_max = 0;
    endtask

    task automatic test_redirect_hold();
        logic [31:0] tgt;
        tgt = 32'h0040_2000 + 32'($urandom_range(255, 0) * 4);
        id_ready = 1'b0;
        for (int i = 0; i < 20 && if_valid !== 1'b1; i++) step();
        checks++;
        if (if_valid !== 1'b1) begin
            failures++; $display("FAIL rh_arrive: got if_valid=%b required 1 within 20 cycles", if_valid);
        end else begin
            id_ready = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc = tgt | 32'($urandom_range(3, 0));
            step();
            redirect_valid = 1'b0;
            checks++;
            if (if_valid !== 1'b0) begin
                failures++; $display("FAIL rh_squash: got if_valid=%b required 0", if_valid);
            end
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== tgt) begin
                failures++; $display("FAIL rh_addr: got req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, tgt);
            end
            for (int i = 0; i < 20 && if_valid !== 1'b1; i++) step();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== tgt) begin
                failures++; $display("FAIL rh_deliver: got v=%b pc=%h required v=1 pc=%h", if_valid, if_pc, tgt);
            end
        end
    endtask

    task automatic test_wrap();
        id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFD;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && if_valid !== 1'b1; i++) step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_pc4 !== 32'h0000_0000) begin
            failures++; $display("FAIL wrap_deliver: got v=%b pc=%h pc4=%h required v=1 pc=fffffffc pc4=00000000",
                                 if_valid, if_pc, if_pc4);
        end
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
            failures++; $display("FAIL wrap_addr: got req=%b addr=%h required req=1 addr=00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_random();
        int start = delivered;
        gnt_pct = 60; lat_min = 0; lat_max = 3; spur_pct = 10;
        for (int i = 0; i < 3000; i++) begin
            id_ready = ($urandom_range(99, 0) < 70);
            rst = ($urandom_range(199, 0) == 0);
            redirect_valid = ($urandom_range(99, 0) < 4);
            if ($urandom_range(9, 0) < 3) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
            else redirect_pc = $urandom;
            step();
        end
        rst = 1'b0; redirect_valid = 1'b0;
        gnt_pct = 100; lat_max = 0; spur_pct = 0;
        checks++;
        if (delivered - start < 50) begin
            failures++; $display("FAIL random_progress: got %0d deliveries required at least 50", delivered - start);
        end
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
        test_reset();
        test_straight_line();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
